// File: rtl/replay_ctrl.sv
// replay_ctrl: sequencing controller for the link-layer TLP replay buffer.
// Tracks NEXT_TRANSMIT_SEQ / ACKD_SEQ, processes ACK/NAK DLLPs, runs the
// replay timer and REPLAY_NUM rollover, and drives purge / replay-read
// commands to the buffer.
// Optional build macro REPLAY_STATS_EN adds replay_cnt / timeout_cnt counters.
module replay_ctrl #(
  parameter int SEQ_W           = 12,
  parameter int TIMER_W         = 16,
  parameter int REPLAY_TIMEOUT  = 1024,
  parameter int MAX_OUTSTANDING = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlp_sent,
  input  logic             dllp_valid,
  input  logic             dllp_nak,
  input  logic [SEQ_W-1:0] dllp_seq,
  input  logic             retrain_done,
  input  logic             buf_rd_ack,
  output logic [SEQ_W-1:0] tx_seq,
  output logic             tx_block,
  output logic             buf_purge,
  output logic [SEQ_W-1:0] buf_purge_seq,
  output logic             buf_rd_req,
  output logic [SEQ_W-1:0] buf_rd_seq,
  output logic             retrain_req,
  output logic             dllp_err
`ifdef REPLAY_STATS_EN
  ,
  output logic [15:0]      replay_cnt,
  output logic [15:0]      timeout_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REPLAY, WAIT_RETRAIN} state_t;

  state_t             state, state_nxt;
  logic [SEQ_W-1:0]   nts, as_q, rp, rp_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [1:0]         replay_num, rnum_nxt, rnum_eff;
  logic               retrain_nxt;

  logic [SEQ_W-1:0]   outstanding, d, as_nxt, nts_nxt, out_after, rp_off;
  logic               in_win, adv, nak_ok, tlp_ok, timer_exp, trig;

  // Window arithmetic, all modulo 2^SEQ_W
  always_comb begin
    outstanding = nts - as_q - 1'b1;
    d           = dllp_seq - as_q;
    in_win      = (d <= outstanding);
    adv         = dllp_valid & in_win & (d != '0);
    nak_ok      = dllp_valid & dllp_nak & in_win;
    as_nxt      = adv ? dllp_seq : as_q;
    tlp_ok      = tlp_sent & ~tx_block;
    nts_nxt     = nts + {{(SEQ_W-1){1'b0}}, tlp_ok};
    out_after   = nts_nxt - as_nxt - 1'b1;
    rp_off      = rp - as_q - 1'b1;
    rnum_eff    = adv ? 2'd0 : replay_num;
    timer_exp   = (state == IDLE) & (outstanding != '0) &
                  (timer == TIMER_W'(REPLAY_TIMEOUT - 1));
    // A forward-progress ACK restarts the timer, so it cancels a coincident expiry;
    // a NAK and an expiry in the same cycle merge into one replay.
    trig        = (state == IDLE) & (out_after != '0) &
                  (nak_ok | (timer_exp & ~(adv & ~dllp_nak)));
  end

  assign tx_seq     = nts;
  assign tx_block   = (state != IDLE) | (outstanding == SEQ_W'(MAX_OUTSTANDING));
  assign buf_rd_req = (state == REPLAY);
  assign buf_rd_seq = (state == REPLAY) ? rp : '0;

  // Next-state, replay pointer, REPLAY_NUM and timer
  always_comb begin
    state_nxt   = state;
    rp_nxt      = rp;
    rnum_nxt    = rnum_eff;
    retrain_nxt = 1'b0;
    timer_nxt   = '0;
    case (state)
      IDLE: begin
        if (trig) begin
          if (rnum_eff == 2'd3) begin
            rnum_nxt    = 2'd0;
            retrain_nxt = 1'b1;
            state_nxt   = WAIT_RETRAIN;
          end else begin
            rnum_nxt  = rnum_eff + 2'd1;
            rp_nxt    = as_nxt + 1'b1;
            state_nxt = REPLAY;
          end
        end else if (outstanding != '0 && !adv && out_after != '0) begin
          timer_nxt = timer + 1'b1;
        end
      end
      WAIT_RETRAIN: begin
        if (retrain_done) begin
          if (out_after == '0) begin
            state_nxt = IDLE;
          end else begin
            rp_nxt    = as_nxt + 1'b1;
            state_nxt = REPLAY;
          end
        end
      end
      REPLAY: begin
        if (out_after == '0) begin
          state_nxt = IDLE;
        end else if (adv && d > rp_off) begin
          // AS overtook the replay pointer: skip what is already acked
          rp_nxt = dllp_seq + 1'b1;
        end else if (buf_rd_ack) begin
          if (rp == nts - 1'b1) state_nxt = IDLE;
          else                  rp_nxt    = rp + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nts           <= '0;
      as_q          <= '1;
      rp            <= '0;
      timer         <= '0;
      replay_num    <= 2'd0;
      buf_purge     <= 1'b0;
      buf_purge_seq <= '0;
      retrain_req   <= 1'b0;
      dllp_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      nts         <= nts_nxt;
      as_q        <= as_nxt;
      rp          <= rp_nxt;
      timer       <= timer_nxt;
      replay_num  <= rnum_nxt;
      buf_purge   <= adv;
      if (adv) buf_purge_seq <= dllp_seq;
      retrain_req <= retrain_nxt;
      dllp_err    <= dllp_valid & ~in_win;
    end
  end

`ifdef REPLAY_STATS_EN
  // Saturating replay / timeout statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      if (trig && replay_cnt != 16'hFFFF)               replay_cnt  <= replay_cnt + 16'd1;
      if (trig && timer_exp && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_replay_ctrl.sv
// Directed bench for replay_ctrl: vector table plus timeout/retrain and
// sequence-wrap sequences.
module tb_replay_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        tlp_sent, dllp_valid, dllp_nak, retrain_done, buf_rd_ack;
  logic [11:0] dllp_seq;
  logic [11:0] tx_seq, buf_purge_seq, buf_rd_seq;
  logic        tx_block, buf_purge, buf_rd_req, retrain_req, dllp_err;

  int checks = 0;
  int errors = 0;

  replay_ctrl dut (
    .clk(clk), .rst(rst), .tlp_sent(tlp_sent), .dllp_valid(dllp_valid),
    .dllp_nak(dllp_nak), .dllp_seq(dllp_seq), .retrain_done(retrain_done),
    .buf_rd_ack(buf_rd_ack), .tx_seq(tx_seq), .tx_block(tx_block),
    .buf_purge(buf_purge), .buf_purge_seq(buf_purge_seq), .buf_rd_req(buf_rd_req),
    .buf_rd_seq(buf_rd_seq), .retrain_req(retrain_req), .dllp_err(dllp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tlp, dv, nak, rtd, ack;
    logic [11:0] seq;
    logic [11:0] e_tx, e_pseq, e_rseq;
    logic e_blk, e_pur, e_req, e_rtr, e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic tlp, dv, nak, input logic [11:0] seq,
                              input logic rtd, ack, input logic [11:0] tx,
                              input logic blk, pur, input logic [11:0] pseq,
                              input logic req, input logic [11:0] rseq,
                              input logic rtr, err);
    vec_t v;
    v.tlp = tlp; v.dv = dv; v.nak = nak; v.seq = seq; v.rtd = rtd; v.ack = ack;
    v.e_tx = tx; v.e_blk = blk; v.e_pur = pur; v.e_pseq = pseq;
    v.e_req = req; v.e_rseq = rseq; v.e_rtr = rtr; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    tlp_sent = 0; dllp_valid = 0; dllp_nak = 0; dllp_seq = '0;
    retrain_done = 0; buf_rd_ack = 0;
  endtask

  task automatic send_dllp(input logic nak, input logic [11:0] s);
    dllp_valid = 1; dllp_nak = nak; dllp_seq = s;
    tick();
    idle_in();
  endtask

  // Wait for buf_rd_req, returning edges elapsed; bounded
  task automatic wait_req(input string nm, input int exp_n);
    int n = 0;
    while (!buf_rd_req && n < 3000) begin tick(); n++; end
    chk(nm, n, exp_n);
  endtask

  // Serve one two-entry replay: seq a then a+1
  task automatic serve2(input string nm, input logic [11:0] a);
    logic [11:0] b;
    b = a + 12'd1;
    chk({nm, " rd_seq0"}, buf_rd_seq, a);
    chk({nm, " blk"}, tx_block, 1);
    buf_rd_ack = 1; tick();
    chk({nm, " rd_seq1"}, buf_rd_seq, b);
    tick(); buf_rd_ack = 0;
    chk({nm, " done req"}, buf_rd_req, 0);
    chk({nm, " done blk"}, tx_block, 0);
  endtask

  initial begin
    idle_in();
    // Expected outputs after the clock edge of each vector
    for (int i = 1; i <= 5; i++) tv.push_back(mk(1,0,0,0,0,0, 12'(i),0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,2,0,0,   5,0,1,2,0,0,0,0));   // ACK 2: purge 2
    tv.push_back(mk(0,0,0,0,0,0,   5,0,0,2,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,   6,0,0,2,0,0,0,0));   // 3 outstanding
    tv.push_back(mk(0,1,1,3,0,0,   6,1,1,3,1,4,0,0));   // NAK 3: purge, replay 4
    tv.push_back(mk(1,0,0,0,0,0,   6,1,0,3,1,4,0,0));   // tlp ignored, rd held
    tv.push_back(mk(0,0,0,0,0,1,   6,1,0,3,1,5,0,0));
    tv.push_back(mk(0,0,0,0,0,0,   6,1,0,3,1,5,0,0));
    tv.push_back(mk(0,0,0,0,0,1,   6,0,0,3,0,0,0,0));   // replay done
    tv.push_back(mk(0,1,0,100,0,0, 6,0,0,3,0,0,0,1));   // out of window
    tv.push_back(mk(0,0,0,0,0,0,   6,0,0,3,0,0,0,0));
    tv.push_back(mk(0,1,0,5,0,0,   6,0,1,5,0,0,0,0));   // ACK 5: all acked
    tv.push_back(mk(0,1,0,5,0,0,   6,0,0,5,0,0,0,0));   // d==0: no purge, no err
    tv.push_back(mk(1,0,0,0,0,0,   7,0,0,5,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,   8,0,0,5,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,   9,0,0,5,0,0,0,0));
    tv.push_back(mk(0,1,1,5,0,0,   9,1,0,5,1,6,0,0));   // NAK d=0: replay 6..8
    tv.push_back(mk(0,1,0,7,0,1,   9,1,1,7,1,8,0,0));   // ACK 7 + rd_ack: ACK wins
    tv.push_back(mk(0,0,0,0,0,1,   9,0,0,7,0,0,0,0));
    tv.push_back(mk(0,1,0,8,0,0,   9,0,1,8,0,0,0,0));

    rst = 1; tick(); tick();
    chk("reset tx_seq", tx_seq, 0);
    chk("reset outs", {tx_block, buf_purge, buf_rd_req, retrain_req, dllp_err}, 0);
    chk("reset seqs", {buf_purge_seq, buf_rd_seq}, 0);
    rst = 0;

    foreach (tv[i]) begin
      tlp_sent = tv[i].tlp; dllp_valid = tv[i].dv; dllp_nak = tv[i].nak;
      dllp_seq = tv[i].seq; retrain_done = tv[i].rtd; buf_rd_ack = tv[i].ack;
      tick();
      idle_in();
      chk($sformatf("vec%0d tx_seq", i), tx_seq, tv[i].e_tx);
      chk($sformatf("vec%0d tx_block", i), tx_block, tv[i].e_blk);
      chk($sformatf("vec%0d purge", i), buf_purge, tv[i].e_pur);
      chk($sformatf("vec%0d purge_seq", i), buf_purge_seq, tv[i].e_pseq);
      chk($sformatf("vec%0d rd_req", i), buf_rd_req, tv[i].e_req);
      chk($sformatf("vec%0d rd_seq", i), buf_rd_seq, tv[i].e_rseq);
      chk($sformatf("vec%0d retrain", i), retrain_req, tv[i].e_rtr);
      chk($sformatf("vec%0d dllp_err", i), dllp_err, tv[i].e_err);
    end

    // Timeouts: NTS=9, AS=8. Send 9,10 and let the timer expire.
    tlp_sent = 1; tick(); tick(); tlp_sent = 0;
    wait_req("timeout1 latency", 1023);
    serve2("timeout1", 12'd9);
    for (int k = 2; k <= 3; k++) begin
      wait_req($sformatf("timeout%0d latency", k), 1024);
      serve2($sformatf("timeout%0d", k), 12'd9);
    end
    begin
      int n = 0;
      while (!tx_block && n < 3000) begin tick(); n++; end
      chk("timeout4 latency", n, 1024);
    end
    chk("rollover retrain_req", retrain_req, 1);
    chk("rollover rd_req", buf_rd_req, 0);
    tick();
    chk("retrain_req pulse", retrain_req, 0);
    repeat (5) tick();
    chk("wait_retrain blk", tx_block, 1);
    chk("wait_retrain req", buf_rd_req, 0);
    retrain_done = 1; tick(); retrain_done = 0;
    chk("post retrain req", buf_rd_req, 1);
    serve2("post retrain", 12'd9);
    send_dllp(0, 12'd10);
    chk("ack10 purge", buf_purge, 1);
    chk("ack10 purge_seq", buf_purge_seq, 10);

    // Walk the sequence space up to AS=4093, NTS=4094
    for (int n = 11; n <= 4093; n++) begin
      tlp_sent = 1; tick(); tlp_sent = 0;
      send_dllp(0, 12'(n));
    end
    chk("walk tx_seq", tx_seq, 4094);
    chk("walk blk", tx_block, 0);
    tlp_sent = 1; tick(); chk("wrap tx 4095", tx_seq, 4095);
    tick(); chk("wrap tx 0", tx_seq, 0);
    tick(); chk("wrap tx 1", tx_seq, 1);
    tlp_sent = 0;
    send_dllp(0, 12'd0);
    chk("wrap purge", buf_purge, 1);
    chk("wrap purge_seq", buf_purge_seq, 0);
    chk("wrap err", dllp_err, 0);
    begin
      int hits = 0;
      for (int c = 0; c < 1100; c++) begin
        tick();
        if (buf_rd_req || tx_block || retrain_req) hits++;
      end
      chk("timer stopped", hits, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/replay_ctrl.md
Name: replay_ctrl

Overview:
Sequencing controller for the TLP replay buffer in the link-layer transmit path.
- Owns the transmit sequence counters, ACK/NAK processing, replay timer and REPLAY_NUM rollover.
- Issues purge and per-sequence replay read commands to the buffer.
- Gates new-TLP transmission while a replay is in progress or the buffer window is exhausted.

Parameters:
SEQ_W, 12, sequence number width; all sequence arithmetic is modulo 2^SEQ_W.
TIMER_W, 16, replay timer width.
REPLAY_TIMEOUT, 1024, timer expiry value in clk cycles.
MAX_OUTSTANDING, 2048, maximum unacknowledged TLPs (must be < 2^SEQ_W).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
tlp_sent  in  1  new TLP committed to buffer and link this cycle; ignored while tx_block=1
dllp_valid  in  1  received ACK/NAK DLLP strobe
dllp_nak  in  1  0=ACK, 1=NAK; qualified by dllp_valid
dllp_seq  in  SEQ_W  AckNak_Seq_Num from the DLLP
retrain_done  in  1  link retrain complete
buf_rd_ack  in  1  buffer accepted current replay read
tx_seq  out  SEQ_W  sequence number to stamp on the next new TLP (NEXT_TRANSMIT_SEQ)
tx_block  out  1  new TLP transmission forbidden
buf_purge  out  1  one-cycle pulse: free all entries up to and including buf_purge_seq
buf_purge_seq  out  SEQ_W  purge boundary
buf_rd_req  out  1  replay read request
buf_rd_seq  out  SEQ_W  sequence number to replay
retrain_req  out  1  one-cycle pulse on REPLAY_NUM rollover
dllp_err  out  1  one-cycle pulse: DLLP sequence out of window, DLLP ignored

Behaviour:
- Reset values: NTS=0; AS=all ones; outstanding=0; timer=0; replay_num=0; state=IDLE; every output 0, except tx_seq=0.
- outstanding = (NTS - AS - 1) mod 2^SEQ_W. d = (dllp_seq - AS) mod 2^SEQ_W.
- tlp_sent with tx_block=0: NTS<=NTS+1 (wraps 4095->0). tx_seq=NTS combinationally.
- tx_block = (state != IDLE) | (outstanding == MAX_OUTSTANDING).
- DLLP window: d > outstanding -> ignored, dllp_err pulses next cycle. d==0 means no forward progress.
- Valid ACK/NAK with d in 1..outstanding, processed in any state:
  - AS<=dllp_seq; buf_purge pulses with buf_purge_seq=dllp_seq, registered, 1-cycle latency.
  - replay_num<=0; timer<=0.
- NAK (d in 0..outstanding) in IDLE with outstanding after the update > 0 triggers a replay. NAK in REPLAY or WAIT_RETRAIN: purge only, no new replay.
- Timer: increments each cycle when state==IDLE and outstanding>0; held at 0 when outstanding==0 or state!=IDLE. timer==REPLAY_TIMEOUT-1 triggers a replay.
- Replay trigger:
  - replay_num==3: replay_num<=0, retrain_req pulses, go to WAIT_RETRAIN.
  - Otherwise: replay_num<=replay_num+1, go to REPLAY with rp=AS+1.
- FSM:
  - IDLE: see triggers above.
  - WAIT_RETRAIN: on retrain_done go to REPLAY with rp=AS+1.
  - REPLAY: buf_rd_req=1 and buf_rd_seq=rp, held stable until buf_rd_ack. On ack: if rp==NTS-1, go to IDLE with timer=0; else rp<=rp+1.
- Boundary rules in REPLAY:
  - ACK with AS advancing to >= rp (modulo window): rp<=AS+1 next cycle.
  - All outstanding acked: drop buf_rd_req, go to IDLE.
  - ACK and buf_rd_ack in the same cycle: ACK has priority for rp.
- Simultaneous tlp_sent and DLLP: both applied; the window check uses the pre-update NTS.
- Timer expiry coincident with a valid NAK: a single replay; replay_num increments once.
- rst mid-replay: immediate return to reset state; buf_rd_req drops the next cycle.

Optional Feature:
REPLAY_STATS_EN
- Defined: adds output ports replay_cnt[15:0] and timeout_cnt[15:0].
  - replay_cnt counts replay initiations; timeout_cnt counts timer-triggered replays.
  - Both saturate at 0xFFFF and clear on rst.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Send 5 TLPs (seq 0-4), ACK seq=2 -> buf_purge with buf_purge_seq=2, outstanding=2, tx_seq=5, no dllp_err.
- 3 TLPs outstanding, NAK seq=0 -> purge 0; tx_block=1; buf_rd_seq 1,2 each held until buf_rd_ack; then IDLE, tx_block=0.
- 2 TLPs outstanding, no DLLP for 1024 cycles -> replay of seq 0,1; replay_num=1; stats build: timeout_cnt=1.
- Four consecutive timeouts, no ACK -> fourth trigger pulses retrain_req and holds tx_block. After retrain_done, replay starts at AS+1; replay_num=0.
- ACK seq=100 with outstanding 3 (AS=4095) -> dllp_err pulse, AS unchanged, no purge.
- NTS wrap: AS=4093, send TLPs 4094, 4095, 0; ACK seq=0 -> purge_seq=0, outstanding=0, timer stopped.
